// File: rtl/eth_speed_detect.sv
// Per-channel link-speed detector: times a prescaled rx toggle against clk,
// classifies 10M/100M/1000M, and commits results after a consecutive-match filter.
module eth_speed_detect #(
  parameter int CHANNELS    = 1,
  parameter int REF_WIDTH   = 7,
  parameter int EDGE_WIDTH  = 2,
  parameter int THRESH_100M = 32,
  parameter int CONFIRM     = 2,
  parameter int SYNC_STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     rx_prescale_msb,
  input  logic [CHANNELS-1:0]     cfg_force_en,
  input  logic [2*CHANNELS-1:0]   cfg_force_speed,
  output logic [2*CHANNELS-1:0]   speed,
  output logic [CHANNELS-1:0]     mii_select,
  output logic [CHANNELS-1:0]     speed_valid,
  output logic [CHANNELS-1:0]     speed_change
);

  localparam int CW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam logic [CW-1:0] CONFIRM_W = CONFIRM[CW-1:0];
  localparam logic [REF_WIDTH:0] THRESH = THRESH_100M[REF_WIDTH:0];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [REF_WIDTH-1:0]   ref_cnt_reg;
      logic [EDGE_WIDTH-1:0]  edge_cnt_reg;
      logic [1:0]             candidate_reg, candidate_next;
      logic [CW-1:0]          confirm_cnt_reg, confirm_cnt_next;
      logic [1:0]             speed_reg, speed_next;
      logic                   valid_reg, valid_next;
      logic                   mii_reg, change_reg;
      logic                   edge_evt, ref_ovf, edge_ovf, result_vld, commit;
      logic [1:0]             result, force_code, force_raw;

      assign edge_evt   = sync_reg[SYNC_STAGES-1] ^ sync_reg[SYNC_STAGES-2];
      assign ref_ovf    = &ref_cnt_reg;
      assign edge_ovf   = &edge_cnt_reg;
      assign result_vld = ref_ovf | edge_ovf;
      assign force_raw  = cfg_force_speed[2*gi +: 2];
      assign force_code = (force_raw == 2'b11) ? 2'b10 : force_raw;

      always_comb begin
        result           = 2'b00;
        candidate_next   = candidate_reg;
        confirm_cnt_next = confirm_cnt_reg;
        commit           = 1'b0;
        speed_next       = speed_reg;
        valid_next       = valid_reg;

        // Edge overflow outranks a simultaneous reference overflow.
        if (edge_ovf)
          result = ({1'b0, ref_cnt_reg} >= THRESH) ? 2'b01 : 2'b10;

        if (result_vld) begin
          if (result == candidate_reg) begin
            if (confirm_cnt_reg < CONFIRM_W)
              confirm_cnt_next = confirm_cnt_reg + 1'b1;
          end else begin
            candidate_next   = result;
            confirm_cnt_next = CW'(1);
          end
          commit = (confirm_cnt_next == CONFIRM_W);
        end

        if (cfg_force_en[gi]) begin
          speed_next = force_code;
          valid_next = 1'b1;
        end else if (commit) begin
          speed_next = candidate_next;
          valid_next = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg        <= '0;
          ref_cnt_reg     <= '0;
          edge_cnt_reg    <= '0;
          candidate_reg   <= 2'b10;
          confirm_cnt_reg <= '0;
          speed_reg       <= 2'b10;
          valid_reg       <= 1'b0;
          mii_reg         <= 1'b0;
          change_reg      <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_prescale_msb[gi]};
          if (result_vld) begin
            ref_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
          end else begin
            ref_cnt_reg  <= ref_cnt_reg + 1'b1;
            edge_cnt_reg <= edge_cnt_reg + {{(EDGE_WIDTH-1){1'b0}}, edge_evt};
          end
          candidate_reg   <= candidate_next;
          confirm_cnt_reg <= confirm_cnt_next;
          speed_reg       <= speed_next;
          valid_reg       <= valid_next;
          mii_reg         <= ~speed_next[1];
          change_reg      <= (speed_next != speed_reg);
        end
      end

      assign speed[2*gi +: 2] = speed_reg;
      assign mii_select[gi]   = mii_reg;
      assign speed_valid[gi]  = valid_reg;
      assign speed_change[gi] = change_reg;
    end
  endgenerate

endmodule

// File: tb/tb_eth_speed_detect.sv
// Directed bench for eth_speed_detect with two channels: table-driven scenarios
// plus hand-written async-reset and alternating-result sequences.
module tb_eth_speed_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rx_prescale_msb = 2'b00;
  logic [1:0] cfg_force_en = 2'b00;
  logic [3:0] cfg_force_speed = 4'b0000;
  logic [3:0] speed;
  logic [1:0] mii_select;
  logic [1:0] speed_valid;
  logic [1:0] speed_change;

  int n_vec = 0;
  int n_err = 0;
  int half [2] = '{0, 0};
  int phase [2] = '{0, 0};
  int pulses [2] = '{0, 0};

  eth_speed_detect #(.CHANNELS(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_prescale_msb (rx_prescale_msb),
    .cfg_force_en    (cfg_force_en),
    .cfg_force_speed (cfg_force_speed),
    .speed           (speed),
    .mii_select      (mii_select),
    .speed_valid     (speed_valid),
    .speed_change    (speed_change)
  );

  always #4 clk = ~clk;

  typedef struct {
    int         half0;
    int         half1;
    logic [1:0] force_en;
    logic [3:0] force_speed;
    int         cycles;
    logic [3:0] exp_speed;
    logic [1:0] exp_valid;
    logic [1:0] exp_mii;
    int         exp_chg0;
    int         exp_chg1;
  } vec_t;

  vec_t vecs [9];

  // One clk cycle: advance the rx toggle generators, tally speed_change pulses.
  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (half[c] != 0) begin
        phase[c]++;
        if (phase[c] >= half[c]) begin
          phase[c] = 0;
          rx_prescale_msb[c] = ~rx_prescale_msb[c];
        end
      end
      if (speed_change[c]) pulses[c]++;
    end
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end else begin
      $display("ok   %s[%0d]: %0h", name, idx, act);
    end
  endtask

  initial begin
    //        h0  h1  fen    fspd     cyc  speed    valid  mii    c0 c1
    vecs[0] = '{0,  4, 2'b00, 4'b0000, 250, 4'b1010, 2'b10, 2'b00, 0, 0};
    vecs[1] = '{0,  4, 2'b00, 4'b0000,  20, 4'b1000, 2'b11, 2'b01, 1, 0};
    vecs[2] = '{0, 20, 2'b00, 4'b0000, 300, 4'b0100, 2'b11, 2'b11, 0, 1};
    vecs[3] = '{0,  4, 2'b00, 4'b0000, 100, 4'b1000, 2'b11, 2'b01, 0, 1};
    vecs[4] = '{0,  4, 2'b01, 4'b0011,   5, 4'b1010, 2'b11, 2'b00, 1, 0};
    vecs[5] = '{0,  4, 2'b11, 4'b0111, 200, 4'b0110, 2'b11, 2'b10, 0, 1};
    vecs[6] = '{0,  4, 2'b10, 4'b0111,   3, 4'b0110, 2'b11, 2'b10, 0, 0};
    vecs[7] = '{0,  4, 2'b10, 4'b0111,  30, 4'b0100, 2'b11, 2'b11, 1, 0};
    vecs[8] = '{0,  4, 2'b00, 4'b0000,  40, 4'b1000, 2'b11, 2'b01, 0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_speed", 0, 32'(speed), 32'h0A);
    check("rst_valid", 0, 32'(speed_valid), 32'h0);
    check("rst_mii", 0, 32'(mii_select), 32'h0);
    check("rst_change", 0, 32'(speed_change), 32'h0);
    half[1] = 4;
    rst = 1'b0;

    // Sequential scenarios: ch0 on a 10M (stuck) link, ch1 at 1000M/100M, forces.
    for (int v = 0; v < 9; v++) begin
      if (half[0] != vecs[v].half0) phase[0] = 0;
      if (half[1] != vecs[v].half1) phase[1] = 0;
      half[0] = vecs[v].half0;
      half[1] = vecs[v].half1;
      cfg_force_en = vecs[v].force_en;
      cfg_force_speed = vecs[v].force_speed;
      pulses[0] = 0;
      pulses[1] = 0;
      repeat (vecs[v].cycles) step();
      check("speed", v, 32'(speed), 32'(vecs[v].exp_speed));
      check("valid", v, 32'(speed_valid), 32'(vecs[v].exp_valid));
      check("mii", v, 32'(mii_select), 32'(vecs[v].exp_mii));
      check("chg0", v, 32'(pulses[0]), 32'(vecs[v].exp_chg0));
      check("chg1", v, 32'(pulses[1]), 32'(vecs[v].exp_chg1));
    end

    // Asynchronous reset between clock edges returns outputs at once.
    @(posedge clk);
    #2;
    half[0] = 0;
    half[1] = 0;
    rx_prescale_msb = 2'b00;
    rst = 1'b1;
    #1;
    check("arst_speed", 1, 32'(speed), 32'h0A);
    check("arst_valid", 1, 32'(speed_valid), 32'h0);
    check("arst_mii", 1, 32'(mii_select), 32'h0);
    check("arst_change", 1, 32'(speed_change), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Alternating 100M / 1000M measurements: filter never confirms.
    pulses[0] = 0;
    pulses[1] = 0;
    for (int g = 0; g < 8; g++) begin
      for (int e = 0; e < 3; e++) begin
        repeat ((g % 2 == 0) ? 20 : 4) step();
        rx_prescale_msb = ~rx_prescale_msb;
      end
    end
    repeat (8) step();
    check("alt_speed", 2, 32'(speed), 32'h0A);
    check("alt_valid", 2, 32'(speed_valid), 32'h0);
    check("alt_chg", 2, 32'(pulses[0] + pulses[1]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
